// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// instruction type codes and PC source selectors.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } seq_state_e;

    localparam logic [1:0] TYPE_DP     = 2'b00;
    localparam logic [1:0] TYPE_MEM    = 2'b01;
    localparam logic [1:0] TYPE_BRANCH = 2'b10;
    localparam logic [1:0] TYPE_HALT   = 2'b11;

    localparam logic [1:0] PCSEL_INC   = 2'b00;
    localparam logic [1:0] PCSEL_ALU   = 2'b01;
    localparam logic [1:0] PCSEL_LINK  = 2'b10;

endpackage

// File: rtl/seq_wait_timer.sv
// Counts cycles spent waiting on a memory ready strobe; expired_o flags the
// cycle in which the WAIT_LIMIT-th consecutive wait cycle occurs.
module seq_wait_timer #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Expiry is combinational so a ready strobe in the same cycle can still win.
    assign expired_o = count_en_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/mem/writeback
// control with memory wait timeout and a retired-instruction counter.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  TypeCode,
    input  logic        Load,
    input  logic        should_store_link,
    input  logic        set_cond_bit,
    input  logic        should_branch_to_link,
    input  logic        write_condition,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_load,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write_en,
    output logic        link_write_en,
    output logic        cpsr_write_en,
    output logic        pc_write_en,
    output logic [1:0]  pc_sel,
    output logic [2:0]  state,
    output logic        fault,
    output logic        halted,
    output logic [31:0] instr_count
);

    seq_state_e  state_q, state_d;
    logic        fault_q, fault_d;
    logic [31:0] instr_count_q, instr_count_d;

    logic imem_req_c, ir_load_c, dmem_req_c, dmem_we_c;
    logic reg_we_c, link_we_c, cpsr_we_c, pc_we_c;
    logic [1:0] pc_sel_c;

    logic timer_clear, timer_count_en, timer_expired;

    assign timer_clear    = ((state_d == FETCH) || (state_d == MEM)) && (state_d != state_q);
    assign timer_count_en = ((state_q == FETCH) && !imem_ready) ||
                            ((state_q == MEM)   && !dmem_ready);

    seq_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (timer_clear),
        .count_en_i (timer_count_en),
        .expired_o  (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        imem_req_c = 1'b0;
        ir_load_c  = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        reg_we_c   = 1'b0;
        link_we_c  = 1'b0;
        cpsr_we_c  = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = PCSEL_INC;
        case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_load_c = 1'b1;
                    state_d   = DECODE;
                end else if (timer_expired) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end
            end
            DECODE: state_d = EXECUTE;
            EXECUTE: begin
                if (!write_condition) begin
                    pc_we_c = 1'b1;
                    state_d = FETCH;
                end else begin
                    case (TypeCode)
                        TYPE_DP:  state_d = WRITEBACK;
                        TYPE_MEM: state_d = MEM;
                        TYPE_BRANCH: begin
                            pc_we_c   = 1'b1;
                            pc_sel_c  = should_branch_to_link ? PCSEL_LINK : PCSEL_ALU;
                            link_we_c = should_store_link;
                            state_d   = FETCH;
                        end
                        default:  state_d = HALT;
                    endcase
                end
            end
            MEM: begin
                // Load=1 marks a store in this decode scheme.
                dmem_req_c = 1'b1;
                dmem_we_c  = Load;
                if (dmem_ready) begin
                    if (Load) begin
                        pc_we_c = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else if (timer_expired) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end
            end
            WRITEBACK: begin
                reg_we_c  = 1'b1;
                cpsr_we_c = set_cond_bit && (TypeCode == TYPE_DP);
                pc_we_c   = 1'b1;
                state_d   = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Enables are masked while reset is held so nothing leaks during reset.
    assign imem_req      = reset && imem_req_c;
    assign ir_load       = reset && ir_load_c;
    assign dmem_req      = reset && dmem_req_c;
    assign dmem_we       = reset && dmem_we_c;
    assign reg_write_en  = reset && reg_we_c;
    assign link_write_en = reset && link_we_c;
    assign cpsr_write_en = reset && cpsr_we_c;
    assign pc_write_en   = reset && pc_we_c;
    assign pc_sel        = reset ? pc_sel_c : PCSEL_INC;

    assign instr_count_d = instr_count_q + {31'd0, pc_write_en};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= FETCH;
            fault_q       <= 1'b0;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            fault_q       <= fault_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state       = state_q;
    assign fault       = fault_q;
    assign halted      = (state_q == HALT);
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: walks each instruction class cycle by
// cycle, then timeout, halt and asynchronous reset behaviour.
module tb_cpu_sequencer;
    import cpu_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  TypeCode = 2'b00;
    logic        Load = 1'b0, should_store_link = 1'b0, set_cond_bit = 1'b0;
    logic        should_branch_to_link = 1'b0, write_condition = 1'b0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        imem_req, ir_load, dmem_req, dmem_we;
    logic        reg_write_en, link_write_en, cpsr_write_en, pc_write_en;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic        fault, halted;
    logic [31:0] instr_count;
    logic [7:0]  en_bus;

    int checks = 0;
    int errors = 0;

    cpu_sequencer #(.WAIT_LIMIT(16)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .TypeCode              (TypeCode),
        .Load                  (Load),
        .should_store_link     (should_store_link),
        .set_cond_bit          (set_cond_bit),
        .should_branch_to_link (should_branch_to_link),
        .write_condition       (write_condition),
        .imem_ready            (imem_ready),
        .dmem_ready            (dmem_ready),
        .imem_req              (imem_req),
        .ir_load               (ir_load),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .reg_write_en          (reg_write_en),
        .link_write_en         (link_write_en),
        .cpsr_write_en         (cpsr_write_en),
        .pc_write_en           (pc_write_en),
        .pc_sel                (pc_sel),
        .state                 (state),
        .fault                 (fault),
        .halted                (halted),
        .instr_count           (instr_count)
    );

    always #10 clock = ~clock;

    // [7]imem_req [6]ir_load [5]dmem_req [4]dmem_we [3]reg [2]link [1]cpsr [0]pc
    assign en_bus = {imem_req, ir_load, dmem_req, dmem_we,
                     reg_write_en, link_write_en, cpsr_write_en, pc_write_en};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input seq_state_e s,
                           input logic [7:0] en_exp, input logic [1:0] sel_exp);
        chk({tag, ".state"},  {29'd0, state},  {29'd0, s});
        chk({tag, ".en"},     {24'd0, en_bus}, {24'd0, en_exp});
        chk({tag, ".pc_sel"}, {30'd0, pc_sel}, {30'd0, sel_exp});
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        #5;
        chk_cyc("rst", FETCH, 8'h00, PCSEL_INC);
        chk("rst.fault", {31'd0, fault}, 32'd0);
        chk("rst.halted", {31'd0, halted}, 32'd0);
        chk("rst.count", instr_count, 32'd0);

        // Data-processing, zero wait
        tick();
        reset = 1'b1; TypeCode = TYPE_DP; set_cond_bit = 1'b1; write_condition = 1'b1;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        #1 chk_cyc("dp.F", FETCH, 8'b1100_0000, PCSEL_INC);
        tick(); #1 chk_cyc("dp.D", DECODE, 8'h00, PCSEL_INC);
        tick(); #1 chk_cyc("dp.E", EXECUTE, 8'h00, PCSEL_INC);
        tick(); #1 chk_cyc("dp.W", WRITEBACK, 8'b0000_1011, PCSEL_INC);
        tick(); #1 chk("dp.count", instr_count, 32'd1);
        $display("txn dp: count=%0d", instr_count);

        // Load with three data wait cycles
        TypeCode = TYPE_MEM; Load = 1'b0; dmem_ready = 1'b0;
        #1 chk_cyc("ld.F", FETCH, 8'b1100_0000, PCSEL_INC);
        tick(); #1 chk_cyc("ld.D", DECODE, 8'h00, PCSEL_INC);
        tick(); #1 chk_cyc("ld.E", EXECUTE, 8'h00, PCSEL_INC);
        for (int i = 1; i <= 3; i++) begin
            tick(); #1 chk_cyc($sformatf("ld.M%0d", i), MEM, 8'b0010_0000, PCSEL_INC);
        end
        tick(); dmem_ready = 1'b1;
        #1 chk_cyc("ld.M4", MEM, 8'b0010_0000, PCSEL_INC);
        tick(); #1 chk_cyc("ld.W", WRITEBACK, 8'b0000_1001, PCSEL_INC);
        tick(); #1 chk("ld.count", instr_count, 32'd2);
        $display("txn load: count=%0d", instr_count);

        // Branch to link with link store
        TypeCode = TYPE_BRANCH; should_branch_to_link = 1'b1; should_store_link = 1'b1;
        #1 chk_cyc("bl.F", FETCH, 8'b1100_0000, PCSEL_INC);
        tick(); #1 chk_cyc("bl.D", DECODE, 8'h00, PCSEL_INC);
        tick(); #1 chk_cyc("bl.E", EXECUTE, 8'b0000_0101, PCSEL_LINK);
        tick(); #1 chk("bl.count", instr_count, 32'd3);
        $display("txn branch-link: count=%0d", instr_count);

        // Branch to ALU target, no link
        should_branch_to_link = 1'b0; should_store_link = 1'b0;
        tick(); #1 chk_cyc("b.D", DECODE, 8'h00, PCSEL_INC);
        tick(); #1 chk_cyc("b.E", EXECUTE, 8'b0000_0001, PCSEL_ALU);
        tick(); #1 chk("b.count", instr_count, 32'd4);
        $display("txn branch: count=%0d", instr_count);

        // Store with failed condition
        TypeCode = TYPE_MEM; Load = 1'b1; write_condition = 1'b0;
        tick(); #1 chk_cyc("stnc.D", DECODE, 8'h00, PCSEL_INC);
        tick(); #1 chk_cyc("stnc.E", EXECUTE, 8'b0000_0001, PCSEL_INC);
        tick(); #1 chk_cyc("stnc.F", FETCH, 8'b1100_0000, PCSEL_INC);
        chk("stnc.count", instr_count, 32'd5);
        $display("txn store-condfail: count=%0d", instr_count);

        // Store, zero wait
        write_condition = 1'b1;
        tick(); #1 chk_cyc("st.D", DECODE, 8'h00, PCSEL_INC);
        tick(); #1 chk_cyc("st.E", EXECUTE, 8'h00, PCSEL_INC);
        tick(); #1 chk_cyc("st.M", MEM, 8'b0011_0001, PCSEL_INC);
        tick(); #1 chk("st.count", instr_count, 32'd6);
        $display("txn store: count=%0d", instr_count);

        // Instruction ready arrives exactly in the 16th fetch cycle
        imem_ready = 1'b0; TypeCode = TYPE_DP; write_condition = 1'b0;
        #1 chk_cyc("w16.F1", FETCH, 8'b1000_0000, PCSEL_INC);
        for (int i = 2; i <= 15; i++) begin
            tick(); #1 chk($sformatf("w16.F%0d", i), {29'd0, state}, {29'd0, FETCH});
        end
        tick(); imem_ready = 1'b1;
        #1 chk_cyc("w16.F16", FETCH, 8'b1100_0000, PCSEL_INC);
        tick(); #1 chk_cyc("w16.D", DECODE, 8'h00, PCSEL_INC);
        chk("w16.fault", {31'd0, fault}, 32'd0);
        tick(); #1 chk_cyc("w16.E", EXECUTE, 8'b0000_0001, PCSEL_INC);
        tick(); #1 chk("w16.count", instr_count, 32'd7);
        $display("txn late-fetch: count=%0d", instr_count);

        // Halt instruction
        TypeCode = TYPE_HALT; write_condition = 1'b1;
        tick(); tick(); tick();
        #1 chk_cyc("hlt.H", HALT, 8'h00, PCSEL_INC);
        chk("hlt.halted", {31'd0, halted}, 32'd1);
        chk("hlt.fault", {31'd0, fault}, 32'd0);
        tick(); #1 chk_cyc("hlt.H2", HALT, 8'h00, PCSEL_INC);
        chk("hlt.count", instr_count, 32'd7);
        $display("txn halt: count=%0d", instr_count);

        // Reset out of HALT, then a store interrupted by reset in MEM
        tick(); reset = 1'b0;
        #1 chk_cyc("rst2", FETCH, 8'h00, PCSEL_INC);
        chk("rst2.halted", {31'd0, halted}, 32'd0);
        tick(); reset = 1'b1; TypeCode = TYPE_MEM; Load = 1'b1; dmem_ready = 1'b0;
        #1 chk("rst2.count", instr_count, 32'd0);
        tick(); tick();
        tick(); #1 chk_cyc("ab.M1", MEM, 8'b0011_0000, PCSEL_INC);
        tick(); #1 chk_cyc("ab.M2", MEM, 8'b0011_0000, PCSEL_INC);
        #4 reset = 1'b0;
        #1 chk_cyc("ab.rst", FETCH, 8'h00, PCSEL_INC);
        chk("ab.count", instr_count, 32'd0);
        tick(); dmem_ready = 1'b1;
        #1 chk_cyc("ab.hold", FETCH, 8'h00, PCSEL_INC);
        $display("txn reset-mid-mem: state=%0d", state);

        // Instruction fetch never ready -> timeout fault
        tick(); reset = 1'b1; imem_ready = 1'b0;
        #1 chk_cyc("to.F1", FETCH, 8'b1000_0000, PCSEL_INC);
        for (int i = 2; i <= 16; i++) begin
            tick(); #1 chk($sformatf("to.F%0d", i), {29'd0, state}, {29'd0, FETCH});
        end
        chk("to.F16.fault", {31'd0, fault}, 32'd0);
        tick(); #1 chk_cyc("to.H", HALT, 8'h00, PCSEL_INC);
        chk("to.fault", {31'd0, fault}, 32'd1);
        chk("to.halted", {31'd0, halted}, 32'd1);
        imem_ready = 1'b1; dmem_ready = 1'b1;
        tick(); #1 chk_cyc("to.H2", HALT, 8'h00, PCSEL_INC);
        chk("to.count", instr_count, 32'd0);
        $display("txn timeout: fault=%0d halted=%0d", fault, halted);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 16, max cycles waiting on any memory ready before fault.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have inputs TypeCode  input  2  decoded type (00 data-proc, 01 memory, 10 branch, 11 halt).
REQ-005 SHALL have inputs Load  input  1, should_store_link  input  1, set_cond_bit  input  1, should_branch_to_link  input  1, all decode fields.
REQ-006 SHALL have input write_condition  input  1  CPSR condition pass for the current instruction.
REQ-007 SHALL have inputs imem_ready  input  1 and dmem_ready  input  1  memory completion strobes.
REQ-008 SHALL have outputs imem_req, ir_load, dmem_req, dmem_we, reg_write_en, link_write_en, cpsr_write_en, pc_write_en (each output 1).
REQ-009 SHALL have output pc_sel  output  2  PC source (00 PC+1, 01 ALU result, 10 link value).
REQ-010 SHALL have outputs state  output  3, fault  output  1, halted  output  1, instr_count  output  32.

Function
REQ-011 SHALL implement FSM states FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
REQ-012 FETCH: imem_req=1; on imem_ready, ir_load pulses one cycle -> DECODE; else stay.
REQ-013 DECODE: one cycle, no enables -> EXECUTE.
REQ-014 EXECUTE with write_condition=0: pc_write_en=1, pc_sel=00 -> FETCH; no register, memory or CPSR write.
REQ-015 EXECUTE, TypeCode 00 -> WRITEBACK; 01 -> MEM; 11 -> HALT (PC not written).
REQ-016 EXECUTE, TypeCode 10: pc_write_en=1, pc_sel=10 if should_branch_to_link else 01; link_write_en=should_store_link; -> FETCH.
REQ-017 MEM: dmem_req=1, dmem_we=Load (Load=1 store, Load=0 load); on dmem_ready: store -> FETCH with pc_write_en, pc_sel=00; load -> WRITEBACK.
REQ-018 WRITEBACK: reg_write_en=1, cpsr_write_en=set_cond_bit & (TypeCode==00), pc_write_en=1, pc_sel=00 -> FETCH.
REQ-019 All enables SHALL be single-cycle combinational decodes of state and inputs; pc_sel=00 whenever pc_write_en=0.
REQ-020 Latency with zero memory wait: data-proc 4 cycles, load 5, store 4, branch 3, condition-failed 3.
REQ-021 Wait counter SHALL clear on entering FETCH or MEM and count each cycle ready is low; reaching WAIT_LIMIT -> HALT, fault=1.
REQ-022 Ready arriving in the same cycle the counter reaches WAIT_LIMIT SHALL win (normal transition, no fault).
REQ-023 HALT: all enables 0, halted=1; exit only by reset.
REQ-024 instr_count SHALL increment on each cycle pc_write_en=1, wrapping 0xFFFFFFFF -> 0.
REQ-025 imem_ready outside FETCH and dmem_ready outside MEM SHALL be ignored.

Reset
REQ-026 reset=0 SHALL immediately force state=FETCH, wait counter=0, instr_count=0, fault=0, halted=0.
REQ-027 While reset=0 all enable outputs SHALL be 0 and pc_sel=00; imem_req asserts the first cycle after release.
REQ-028 Reset mid-MEM SHALL abort the access with no dmem_we/reg_write_en in any later cycle of that instruction.

Structure
REQ-029 Shared package cpu_seq_pkg SHALL hold state encoding (FETCH=0 .. HALT=5), TypeCode constants and pc_sel constants.
REQ-030 Wait counter SHALL be sub-module seq_wait_timer (clear, count enable, limit parameter, expired output).

Verification
REQ-031 DP instr, TypeCode=00, set_cond_bit=1, readies tied 1 -> states F,D,E,W; reg_write_en, cpsr_write_en, pc_write_en high in cycle 4 only; instr_count=1.
REQ-032 Load, TypeCode=01, Load=0, dmem_ready after 3 wait cycles -> MEM held 4 cycles, dmem_we=0, reg_write_en in following WRITEBACK.
REQ-033 Branch TypeCode=10, should_branch_to_link=1, should_store_link=1 -> cycle 3: pc_sel=10, pc_write_en=1, link_write_en=1.
REQ-034 Store with write_condition=0 -> no dmem_req, pc_sel=00, returns FETCH after 3 cycles.
REQ-035 imem_ready held 0 with WAIT_LIMIT=16 -> fault=1, halted=1 after 16 FETCH cycles; ready in cycle 16 -> DECODE, no fault.
REQ-036 reset=0 asserted mid-MEM store -> outputs zeroed asynchronously, instr_count=0, FETCH on release.
